// File: rtl/sec_search.sv
// sec_search: sequential single-error search for an AN-coded word.
//
// A codeword is accepted in IDLE and its syndrome (cw mod MOD_A) is built one bit per cycle,
// MSB first. A nonzero syndrome is then compared against the remainder for each candidate error
// location. Candidates are tried in the order 1,-1,2,-2,...,CW,-CW. The external lookup returns
// each remainder combinationally on lut_r. The first match is corrected by adding or subtracting
// 2^(|l|-1). A correction that leaves the CW-bit range is reported as uncorrectable.
//
// Optional feature macro: SEC_CONST_LATENCY_EN. When it is defined, every codeword takes the full
// scan of 2*CW candidates, so the result latency does not depend on the data.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; cw_in is sampled only on acceptance
//   cw_in               received codeword
//   lut_l / lut_r       signed candidate location out, its remainder back (same cycle)
//   out_valid/out_ready result handshake; results held stable until accepted
//   cw_out, err_loc     corrected codeword, signed matched location (0 if none)
//   no_err, corrected, uncorr  one-hot result status
module sec_search #(
    parameter int unsigned CW    = 45,
    parameter int unsigned MOD_A = 18613,
    parameter int unsigned RW    = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW-1:0]        cw_in,
    output logic signed [6:0]    lut_l,
    input  logic [RW-1:0]        lut_r,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        cw_out,
    output logic signed [6:0]    err_loc,
    output logic                 no_err,
    output logic                 corrected,
    output logic                 uncorr
);

    typedef enum logic [1:0] {StIdle, StRes, StSearch, StDone} state_e;

    localparam int unsigned      CntW    = (CW > 1) ? $clog2(CW) : 1;
    localparam logic [RW:0]      ModExt  = (RW+1)'(MOD_A);
    localparam logic signed [6:0] LocLast = 7'(-int'(CW));

    state_e               state_q, state_d;
    logic [CW-1:0]        cw_q, cw_d;
    logic [RW-1:0]        syn_q, syn_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic signed [6:0]    lut_l_q, lut_l_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [CW-1:0]        cw_out_q, cw_out_d;
    logic signed [6:0]    err_loc_q, err_loc_d;
    logic                 no_err_q, no_err_d;
    logic                 corrected_q, corrected_d;
    logic                 uncorr_q, uncorr_d;
`ifdef SEC_CONST_LATENCY_EN
    // Set once a result is recorded; later matches in the same scan are ignored.
    logic                 found_q, found_d;
`endif

    logic [RW:0]          syn_dbl;
    logic [RW-1:0]        syn_step;
    logic                 match;
    logic                 last_cand;
    logic signed [6:0]    next_l;
    logic [6:0]           mag;
    logic [CW:0]          pow;
    logic [CW:0]          cw_ext;
    logic [CW:0]          cw_sub;
    logic [CW:0]          cw_add;
    logic                 corr_ok;
    logic [CW-1:0]        corr_cw;

    // Datapath: syndrome step, candidate sequencing, and trial correction for the current candidate.
    always_comb begin
        // syn < A, so 2*syn+bit < 2A and a single conditional subtract keeps it reduced.
        syn_dbl   = {syn_q, cw_q[cnt_q]};
        syn_step  = (syn_dbl >= ModExt) ? RW'(syn_dbl - ModExt) : syn_dbl[RW-1:0];
        match     = (lut_r == syn_q);
        last_cand = (lut_l_q == LocLast);
        // l>0 -> -l ; l<0 -> |l|+1
        next_l    = lut_l_q[6] ? (7'sd1 - lut_l_q) : -lut_l_q;
        mag       = lut_l_q[6] ? -lut_l_q : lut_l_q;
        pow       = {{CW{1'b0}}, 1'b1} << (mag - 7'd1);
        cw_ext    = {1'b0, cw_q};
        cw_sub    = cw_ext - pow;
        cw_add    = cw_ext + pow;
        // The extra top bit flags a borrow below zero or a carry past 2^CW-1.
        if (lut_l_q[6]) begin
            corr_ok = ~cw_add[CW];
            corr_cw = cw_add[CW-1:0];
        end else begin
            corr_ok = ~cw_sub[CW];
            corr_cw = cw_sub[CW-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        cw_d        = cw_q;
        syn_d       = syn_q;
        cnt_d       = cnt_q;
        lut_l_d     = lut_l_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        cw_out_d    = cw_out_q;
        err_loc_d   = err_loc_q;
        no_err_d    = no_err_q;
        corrected_d = corrected_q;
        uncorr_d    = uncorr_q;
`ifdef SEC_CONST_LATENCY_EN
        found_d     = found_q;
`endif

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    cw_d       = cw_in;
                    syn_d      = '0;
                    cnt_d      = CntW'(CW - 1);
                    in_ready_d = 1'b0;
                    state_d    = StRes;
                end
            end

            StRes: begin
                syn_d = syn_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
`ifdef SEC_CONST_LATENCY_EN
                    // A zero syndrome records its result now but still runs the full scan.
                    state_d = StSearch;
                    lut_l_d = 7'sd1;
                    found_d = (syn_step == '0);
                    if (syn_step == '0) begin
                        no_err_d    = 1'b1;
                        corrected_d = 1'b0;
                        uncorr_d    = 1'b0;
                        err_loc_d   = '0;
                        cw_out_d    = cw_q;
                    end
`else
                    if (syn_step == '0) begin
                        state_d     = StDone;
                        out_valid_d = 1'b1;
                        no_err_d    = 1'b1;
                        corrected_d = 1'b0;
                        uncorr_d    = 1'b0;
                        err_loc_d   = '0;
                        cw_out_d    = cw_q;
                    end else begin
                        state_d = StSearch;
                        lut_l_d = 7'sd1;
                    end
`endif
                end
            end

            StSearch: begin
                lut_l_d = next_l;
`ifdef SEC_CONST_LATENCY_EN
                if (!found_q && match) begin
                    found_d     = 1'b1;
                    no_err_d    = 1'b0;
                    err_loc_d   = lut_l_q;
                    corrected_d = corr_ok;
                    uncorr_d    = ~corr_ok;
                    cw_out_d    = corr_ok ? corr_cw : cw_q;
                end
                if (last_cand) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    lut_l_d     = '0;
                    if (!found_q && !match) begin
                        no_err_d    = 1'b0;
                        err_loc_d   = '0;
                        corrected_d = 1'b0;
                        uncorr_d    = 1'b1;
                        cw_out_d    = cw_q;
                    end
                end
`else
                if (match || last_cand) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    lut_l_d     = '0;
                    no_err_d    = 1'b0;
                    if (match) begin
                        err_loc_d   = lut_l_q;
                        corrected_d = corr_ok;
                        uncorr_d    = ~corr_ok;
                        cw_out_d    = corr_ok ? corr_cw : cw_q;
                    end else begin
                        err_loc_d   = '0;
                        corrected_d = 1'b0;
                        uncorr_d    = 1'b1;
                        cw_out_d    = cw_q;
                    end
                end
`endif
            end

            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end

            default: begin
                state_d    = StIdle;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cw_q        <= '0;
            syn_q       <= '0;
            cnt_q       <= '0;
            lut_l_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cw_out_q    <= '0;
            err_loc_q   <= '0;
            no_err_q    <= 1'b0;
            corrected_q <= 1'b0;
            uncorr_q    <= 1'b0;
`ifdef SEC_CONST_LATENCY_EN
            found_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cw_q        <= cw_d;
            syn_q       <= syn_d;
            cnt_q       <= cnt_d;
            lut_l_q     <= lut_l_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cw_out_q    <= cw_out_d;
            err_loc_q   <= err_loc_d;
            no_err_q    <= no_err_d;
            corrected_q <= corrected_d;
            uncorr_q    <= uncorr_d;
`ifdef SEC_CONST_LATENCY_EN
            found_q     <= found_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign lut_l     = lut_l_q;
    assign cw_out    = cw_out_q;
    assign err_loc   = err_loc_q;
    assign no_err    = no_err_q;
    assign corrected = corrected_q;
    assign uncorr    = uncorr_q;

endmodule

// File: tb/tb_sec_search.sv
`timescale 1ns/1ps
module tb_sec_search;

    localparam int unsigned CW    = 45;
    localparam int unsigned MOD_A = 18613;
    localparam int unsigned RW    = 15;
    localparam longint      A     = 18613;
    localparam longint      TOP   = (longint'(1) <<< CW) - 1;

    typedef struct {
        longint cw_out;
        int     loc;
        bit     no_err;
        bit     corr;
        bit     unc;
        int     lat;
    } exp_t;

    typedef struct {
        longint cw;
        exp_t   e;
        int     hold;
    } vec_t;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [CW-1:0]        cw_in;
    logic signed [6:0]    lut_l;
    logic [RW-1:0]        lut_r;
    logic                 out_valid;
    logic                 out_ready;
    logic [CW-1:0]        cw_out;
    logic signed [6:0]    err_loc;
    logic                 no_err;
    logic                 corrected;
    logic                 uncorr;

    int checks   = 0;
    int failures = 0;

    sec_search #(
        .CW    (CW),
        .MOD_A (MOD_A),
        .RW    (RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cw_in     (cw_in),
        .lut_l     (lut_l),
        .lut_r     (lut_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cw_out    (cw_out),
        .err_loc   (err_loc),
        .no_err    (no_err),
        .corrected (corrected),
        .uncorr    (uncorr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Candidate location for search index j: 1,-1,2,-2,...
    function automatic int cand(input int j);
        return (j % 2 == 1) ? (j + 1) / 2 : -(j / 2);
    endfunction

    // Location-to-remainder lookup.
    function automatic longint lut_f(input int l);
        longint p;
        int     m;
        if (l == 0) return 0;
        m = (l > 0) ? l : -l;
        p = (longint'(1) <<< (m - 1)) % A;
        return (l > 0) ? p : A - p;
    endfunction

    always_comb lut_r = RW'(lut_f(int'(lut_l)));

    // Reference: whole-word modulus, linear candidate scan, arithmetic correction.
    function automatic exp_t model(input longint cw);
        exp_t   e;
        longint syn;
        longint p;
        int     l;
        e.cw_out = cw;
        e.loc    = 0;
        e.no_err = 1'b0;
        e.corr   = 1'b0;
        e.unc    = 1'b0;
        e.lat    = 3 * CW + 1;
        syn = cw % A;
        if (syn == 0) begin
            e.no_err = 1'b1;
            e.lat    = CW + 1;
        end else begin
            e.unc = 1'b1;
            for (int j = 1; j <= 2 * CW; j++) begin
                l = cand(j);
                if (lut_f(l) == syn) begin
                    e.loc = l;
                    e.lat = CW + 1 + j;
                    p = longint'(1) <<< (((l > 0) ? l : -l) - 1);
                    if (l > 0 && cw >= p) begin
                        e.corr = 1'b1; e.unc = 1'b0; e.cw_out = cw - p;
                    end else if (l < 0 && cw + p <= TOP) begin
                        e.corr = 1'b1; e.unc = 1'b0; e.cw_out = cw + p;
                    end
                    break;
                end
            end
        end
`ifdef SEC_CONST_LATENCY_EN
        e.lat = 3 * CW + 1;
`endif
        return e;
    endfunction

    function automatic vec_t mk(input longint cw, input bit ne, input bit co, input bit un,
                                input int loc, input longint out, input int lat, input int hold);
        vec_t v;
        v.cw       = cw;
        v.e.no_err = ne;
        v.e.corr   = co;
        v.e.unc    = un;
        v.e.loc    = loc;
        v.e.cw_out = out;
        v.e.lat    = lat;
        v.hold     = hold;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic chk_result(input string tag, input exp_t e);
        chk({tag, " out_valid"}, longint'(out_valid), 1);
        chk({tag, " cw_out"}, longint'(cw_out), e.cw_out);
        chk({tag, " err_loc"}, longint'(err_loc), e.loc);
        chk({tag, " no_err"}, longint'(no_err), longint'(e.no_err));
        chk({tag, " corrected"}, longint'(corrected), longint'(e.corr));
        chk({tag, " uncorr"}, longint'(uncorr), longint'(e.unc));
    endtask

    // Caller is positioned 1ns after a rising edge with the DUT idle.
    task automatic do_txn(input string tag, input longint cw, input exp_t e, input int hold);
        int     cur;
        bit     seen;
        longint exp_l;
        chk({tag, " in_ready idle"}, longint'(in_ready), 1);
        in_valid = 1'b1;
        cw_in    = CW'(cw);
        @(posedge clk); #1;
        cur = 1;
        // Garbage on the input side while busy must be ignored.
        in_valid = 1'($urandom_range(0, 1));
        cw_in    = CW'({$urandom(), $urandom()});
        chk({tag, " in_ready busy"}, longint'(in_ready), 0);
        seen = 1'b0;
        while (cur <= 200) begin
            exp_l = (cur >= CW + 1 && cur < e.lat) ? longint'(cand(cur - CW)) : 0;
            chk($sformatf("%s lut_l@%0d", tag, cur), longint'(lut_l), exp_l);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cur++;
            in_valid = 1'($urandom_range(0, 1));
            cw_in    = CW'({$urandom(), $urandom()});
        end
        in_valid = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: no out_valid after %0d cycles, expected at %0d",
                     tag, cur, e.lat);
            rst = 1'b1; #2; rst = 1'b0;
            @(posedge clk); #1;
            return;
        end
        chk({tag, " latency"}, longint'(cur), longint'(e.lat));
        chk_result(tag, e);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk_result($sformatf("%s hold%0d", tag, h), e);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " out_valid cleared"}, longint'(out_valid), 0);
        chk({tag, " in_ready back"}, longint'(in_ready), 1);
    endtask

    // Start a codeword and reset asynchronously in the middle of cycle `at`.
    task automatic do_abort(input string tag, input longint cw, input int at);
        in_valid = 1'b1;
        cw_in    = CW'(cw);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (at - 1) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk({tag, " in_ready async"}, longint'(in_ready), 1);
        chk({tag, " out_valid async"}, longint'(out_valid), 0);
        chk({tag, " lut_l async"}, longint'(lut_l), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("%s no result %0d", tag, i), longint'(out_valid), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs [7];
        exp_t   e;
        longint cw;
        longint n;
        longint p;
        longint nmul;
        longint ovf_cw;

        vecs[0] = mk(18613000, 1, 0, 0,  0, 18613000,  46, 0);
        vecs[1] = mk(18613016, 0, 1, 0,  5, 18613000,  55, 2);
        vecs[2] = mk(18612999, 0, 1, 0, -1, 18613000,  48, 0);
        vecs[3] = mk(3,        0, 0, 1,  0, 3,         136, 5);
        vecs[4] = mk(0,        1, 0, 0,  0, 0,          46, 0);
        // syn=14155=2^15 mod A matches l=16 (j=31); 14155-2^15 borrows.
        vecs[5] = mk(14155,    0, 0, 1, 16, 14155,      77, 1);
        vecs[6] = mk(16,       0, 1, 0,  5, 0,          55, 0);

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cw_in     = '0;
        #7;
        chk("reset in_ready", longint'(in_ready), 1);
        chk("reset out_valid", longint'(out_valid), 0);
        chk("reset lut_l", longint'(lut_l), 0);
        chk("reset cw_out", longint'(cw_out), 0);
        chk("reset err_loc", longint'(err_loc), 0);
        chk("reset no_err", longint'(no_err), 0);
        chk("reset corrected", longint'(corrected), 0);
        chk("reset uncorr", longint'(uncorr), 0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
`ifdef SEC_CONST_LATENCY_EN
            vecs[i].e.lat = 3 * CW + 1;
`endif
            do_txn($sformatf("vec%0d", i), vecs[i].cw, vecs[i].e, vecs[i].hold);
        end

        do_abort("abort_res", 18613016, 20);
        do_txn("after_abort_res", 18613000, model(18613000), 0);
        do_abort("abort_search", 3, 80);
        do_txn("after_abort_search", 18613000, model(18613000), 0);

        // Overflow: cw + 2^(m-1) is a multiple of A just above 2^CW-1.
        nmul   = (TOP / A + 1) * A;
        ovf_cw = -1;
        for (int m = CW; m >= 2; m--) begin
            cw = nmul - (longint'(1) <<< (m - 1));
            if (cw >= 0 && cw <= TOP) begin
                e = model(cw);
                if (e.unc && e.loc == -m) begin
                    ovf_cw = cw;
                    break;
                end
            end
        end
        if (ovf_cw < 0) begin
            checks++;
            failures++;
            $display("FAIL overflow setup: no codeword found, got -1 expected >=0");
        end else begin
            do_txn("overflow", ovf_cw, model(ovf_cw), 1);
        end
        do_txn("all_ones", TOP, model(TOP), 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: cw = longint'({$urandom(), $urandom()}) & TOP;
                1: cw = (longint'($urandom()) % (TOP / A + 1)) * A;
                default: begin
                    n  = longint'($urandom()) % (TOP / A + 1);
                    p  = longint'(1) <<< $urandom_range(0, CW - 1);
                    cw = $urandom_range(0, 1) ? n * A + p : n * A - p;
                    if (cw < 0 || cw > TOP) cw = n * A;
                end
            endcase
            do_txn($sformatf("rand%0d", i), cw, model(cw), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
